// File: rtl/alarm_sequencer.sv
// Intrusion alarm sequencer: arm -> exit delay -> armed -> entry delay -> alarm latch, disarm always wins.
// Latency: outputs decode the state register directly, so a transition is visible right after its edge.
// Backpressure: none; level inputs are sampled every clk_2 edge. Optional auto-silence: ALARM_AUTO_SILENCE_EN.
module alarm_sequencer #(
   parameter int EXIT_DLY    = 8,
   parameter int ENTRY_DLY   = 4,
   parameter int BLINK_HALF  = 2,
   parameter int SILENCE_CYC = 16
) (
   input  logic       clk_2,
   input  logic       rst_n,
   input  logic       arm,
   input  logic       disarm,
   input  logic       trigger,
   output logic       siren,
   output logic       armed,
   output logic       blink,
   output logic [2:0] state,
   output logic [7:0] count
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_EXIT     = 3'd1,
      S_ARMED    = 3'd2,
      S_ENTRY    = 3'd3,
      S_ALARM    = 3'd4,
      S_SILENCED = 3'd5
   } st_t;

   // An out-of-range parameter set leaves the block inert: it never leaves IDLE.
   localparam bit CFG_OK = (EXIT_DLY    >= 1) && (EXIT_DLY    <= 255) &&
                           (ENTRY_DLY   >= 1) && (ENTRY_DLY   <= 255) &&
                           (BLINK_HALF  >= 1) && (BLINK_HALF  <= 255) &&
                           (SILENCE_CYC >= 1) && (SILENCE_CYC <= 255);

   localparam logic [7:0] EXIT_LOAD  = 8'(EXIT_DLY);
   localparam logic [7:0] ENTRY_LOAD = 8'(ENTRY_DLY);
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_HALF - 1);

   st_t        cur_st, nxt_st;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] bcnt_q;
   logic       blink_q;
   logic       arm_q;
   logic       arm_rise;

`ifdef ALARM_AUTO_SILENCE_EN
   localparam logic [7:0] SIL_LAST = 8'(SILENCE_CYC - 1);
   logic [7:0] sil_q, sil_d;
`endif

   assign arm_rise = arm & ~arm_q;

   // State, delay counter, arm edge register (and alarm-age counter when auto-silence is built).
   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         cur_st <= S_IDLE;
         cnt_q  <= 8'd0;
         arm_q  <= 1'b0;
`ifdef ALARM_AUTO_SILENCE_EN
         sil_q  <= 8'd0;
`endif
      end else begin
         cur_st <= nxt_st;
         cnt_q  <= cnt_d;
         arm_q  <= arm;
`ifdef ALARM_AUTO_SILENCE_EN
         sil_q  <= sil_d;
`endif
      end
   end

   // Next-state and delay countdown; disarm overrides everything at the end.
   always_comb begin
      nxt_st = cur_st;
      cnt_d  = 8'd0;
`ifdef ALARM_AUTO_SILENCE_EN
      sil_d  = 8'd0;
`endif
      case (cur_st)
         S_IDLE: begin
            if (arm_rise && CFG_OK) begin
               nxt_st = S_EXIT;
               cnt_d  = EXIT_LOAD;
            end
         end
         S_EXIT: begin
            if (cnt_q == 8'd1) nxt_st = S_ARMED;
            else               cnt_d  = cnt_q - 8'd1;
         end
         S_ARMED: begin
            if (trigger) begin
               nxt_st = S_ENTRY;
               cnt_d  = ENTRY_LOAD;
            end
         end
         S_ENTRY: begin
            if (cnt_q == 8'd1) nxt_st = S_ALARM;
            else               cnt_d  = cnt_q - 8'd1;
         end
         S_ALARM: begin
`ifdef ALARM_AUTO_SILENCE_EN
            if (sil_q == SIL_LAST) nxt_st = S_SILENCED;
            else                   sil_d  = sil_q + 8'd1;
`else
            nxt_st = S_ALARM;
`endif
         end
`ifdef ALARM_AUTO_SILENCE_EN
         S_SILENCED: nxt_st = S_SILENCED;
`endif
         default: nxt_st = S_IDLE;
      endcase
      if (disarm) begin
         nxt_st = S_IDLE;
         cnt_d  = 8'd0;
`ifdef ALARM_AUTO_SILENCE_EN
         sil_d  = 8'd0;
`endif
      end
   end

   // Blink: off in IDLE/ARMED, restarts high when a blinking phase begins, then toggles every BLINK_HALF cycles.
   always_ff @(posedge clk_2 or negedge rst_n) begin
      if (!rst_n) begin
         blink_q <= 1'b0;
         bcnt_q  <= 8'd0;
      end else if (nxt_st == S_IDLE || nxt_st == S_ARMED) begin
         blink_q <= 1'b0;
         bcnt_q  <= 8'd0;
      end else if (cur_st == S_IDLE || cur_st == S_ARMED) begin
         blink_q <= 1'b1;
         bcnt_q  <= 8'd0;
      end else if (bcnt_q == BLINK_LAST) begin
         blink_q <= ~blink_q;
         bcnt_q  <= 8'd0;
      end else begin
         bcnt_q  <= bcnt_q + 8'd1;
      end
   end

   assign state = cur_st;
   assign count = cnt_q;
   assign blink = blink_q;
   assign siren = (cur_st == S_ALARM);
   assign armed = (cur_st == S_ARMED) || (cur_st == S_ENTRY) ||
                  (cur_st == S_ALARM) || (cur_st == S_SILENCED);

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed scenarios followed by random stimulus, all compared against a phase-based reference model.
// Outputs are checked 1 time unit after each rising edge; inputs change only at that point or at negedges.
// No backpressure on this block; every step is a fixed number of clock edges.
module tb_alarm_sequencer;

   localparam int EXIT_DLY    = 8;
   localparam int ENTRY_DLY   = 4;
   localparam int BLINK_HALF  = 2;
   localparam int SILENCE_CYC = 16;

   logic       clk_2 = 1'b0;
   logic       rst_n;
   logic       arm, disarm, trigger;
   logic       siren, armed, blink;
   logic [2:0] state;
   logic [7:0] count;

   int total = 0;
   int bad   = 0;

   // Reference model: state number, remaining delay, age of current blinking phase, age in ALARM.
   int m_st, m_cnt, m_run, m_alarm_age;
   bit m_prev_arm;

   alarm_sequencer #(
      .EXIT_DLY(EXIT_DLY), .ENTRY_DLY(ENTRY_DLY),
      .BLINK_HALF(BLINK_HALF), .SILENCE_CYC(SILENCE_CYC)
   ) dut (
      .clk_2(clk_2), .rst_n(rst_n), .arm(arm), .disarm(disarm), .trigger(trigger),
      .siren(siren), .armed(armed), .blink(blink), .state(state), .count(count)
   );

   always #5 clk_2 = ~clk_2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit is_blink_state(input int s);
      return (s == 1) || (s == 3) || (s == 4) || (s == 5);
   endfunction

   task automatic model_reset();
      m_st = 0; m_cnt = 0; m_run = 0; m_alarm_age = 0; m_prev_arm = 0;
   endtask

   task automatic model_edge();
      int old;
      bit rise;
      old  = m_st;
      rise = arm && !m_prev_arm;
      m_prev_arm = arm;
      if (disarm) begin
         m_st = 0; m_cnt = 0;
      end else begin
         case (m_st)
            0: if (rise) begin m_st = 1; m_cnt = EXIT_DLY; end
            1: if (m_cnt == 1) begin m_st = 2; m_cnt = 0; end else m_cnt--;
            2: if (trigger) begin m_st = 3; m_cnt = ENTRY_DLY; end
            3: if (m_cnt == 1) begin m_st = 4; m_cnt = 0; m_alarm_age = 0; end else m_cnt--;
            4: begin
`ifdef ALARM_AUTO_SILENCE_EN
               m_alarm_age++;
               if (m_alarm_age == SILENCE_CYC) m_st = 5;
`endif
            end
            default: ;
         endcase
      end
      if (!is_blink_state(m_st))     m_run = 0;
      else if (!is_blink_state(old)) m_run = 0;
      else                           m_run++;
   endtask

   task automatic check_all();
      chk("state", state, m_st);
      chk("count", count, m_cnt);
      chk("siren", siren, (m_st == 4));
      chk("armed", armed, (m_st >= 2 && m_st <= 5));
      chk("blink", blink, is_blink_state(m_st) ? (((m_run / BLINK_HALF) % 2) == 0) : 0);
   endtask

   task automatic tick();
      @(posedge clk_2);
      model_edge();
      #1;
      check_all();
   endtask

   // Called 1 time unit after an edge: reset lands between edges and must act immediately.
   task automatic reset_mid();
      rst_n = 1'b0;
      #1;
      chk("async_rst_siren", siren, 0);
      chk("async_rst_state", state, 0);
      model_reset();
      check_all();
      @(negedge clk_2);
      rst_n = 1'b1;
   endtask

   task automatic run_to_alarm();
      arm = 1; tick(); arm = 0;
      repeat (EXIT_DLY) tick();
      trigger = 1; tick(); trigger = 0;
      repeat (ENTRY_DLY) tick();
   endtask

   initial begin
      logic b0;
      rst_n = 1'b0; arm = 0; disarm = 0; trigger = 0;
      model_reset();
      #12;
      chk("rst_state", state, 0);
      chk("rst_count", count, 0);
      chk("rst_siren", siren, 0);
      chk("rst_armed", armed, 0);
      chk("rst_blink", blink, 0);
      @(negedge clk_2);
      rst_n = 1'b1;
      tick();

      // Arm pulse: exit countdown 8..1, ARMED on the 8th edge after the rise.
      arm = 1; tick();
      chk("exit_enter_state", state, 1);
      chk("exit_enter_count", count, 8);
      chk("exit_enter_blink", blink, 1);
      arm = 0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("exit_count", count, 8 - i);
         chk("exit_siren", siren, 0);
      end
      tick();
      chk("armed_state", state, 2);
      chk("armed_count", count, 0);

      // Trigger pulse in ARMED: entry 4..1, then latched ALARM.
      trigger = 1; tick();
      chk("entry_state", state, 3);
      chk("entry_count", count, 4);
      trigger = 0;
      repeat (3) tick();
      chk("entry_last", count, 1);
      tick();
      chk("alarm_state", state, 4);
      chk("alarm_siren", siren, 1);
      repeat (2) tick();
      chk("alarm_latched", siren, 1);
      disarm = 1; tick(); disarm = 0;
      chk("disarm_alarm", state, 0);

      // Disarm during ENTRY with count=2.
      arm = 1; tick(); arm = 0;
      repeat (EXIT_DLY) tick();
      trigger = 1; tick(); trigger = 0;
      tick(); tick();
      chk("entry_cnt2", count, 2);
      disarm = 1; tick();
      chk("dis_state", state, 0);
      chk("dis_count", count, 0);
      chk("dis_siren", siren, 0);
      chk("dis_armed", armed, 0);
      chk("dis_blink", blink, 0);
      disarm = 0;

      // Trigger held through EXIT is ignored; ENTRY follows ARMED immediately.
      arm = 1; tick(); arm = 0;
      trigger = 1;
      repeat (7) tick();
      chk("exit_ignores_trig", state, 1);
      tick();
      chk("armed_on_schedule", state, 2);
      tick();
      chk("entry_after_armed", state, 3);
      trigger = 0;
      repeat (ENTRY_DLY) tick();
      chk("alarm_again", state, 4);

      // Long ALARM: auto-silence after 16 cycles when built in, otherwise siren stays on.
      repeat (SILENCE_CYC - 1) tick();
      chk("alarm_pre_sil", state, 4);
      tick();
`ifdef ALARM_AUTO_SILENCE_EN
      chk("sil_state", state, 5);
      chk("sil_siren", siren, 0);
      chk("sil_armed", armed, 1);
      b0 = blink;
      tick(); tick();
      chk("sil_blink_toggle", blink, !b0);
      trigger = 1; tick(); trigger = 0;
      chk("sil_retrigger", state, 5);
      repeat (100 - SILENCE_CYC - 3) tick();
      chk("sil_hold", state, 5);
`else
      chk("no_sil_state", state, 4);
      repeat (100 - SILENCE_CYC) tick();
      chk("siren_100", siren, 1);
      chk("state_100", state, 4);
`endif
      disarm = 1; tick(); disarm = 0;

      // Asynchronous reset mid-ALARM, then simultaneous arm rise and disarm in IDLE.
      run_to_alarm();
      chk("alarm_pre_rst", siren, 1);
      reset_mid();
      arm = 1; disarm = 1; tick();
      chk("arm_dis_same", state, 0);
      arm = 0; disarm = 0; tick();

      // Random stimulus against the model.
      for (int i = 0; i < 900; i++) begin
         arm     = ($urandom_range(0, 3) == 0);
         disarm  = ($urandom_range(0, 29) == 0);
         trigger = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 199) == 0) reset_mid();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
